lcd_timing_gen: RTL and testbench
=================================

Name: lcd_timing_gen

Overview:
- Display timing controller for the 800x480 panel; the driving end of the pixel interface whose consumer is the picture/colour generator.
- Runs free-running horizontal and vertical counters and issues pixel-coordinate requests (pix_x/pix_y) PIX_LEAD cycles ahead of display. This lead time covers the generator's ROM/pipeline latency.
- Samples the returned 24-bit colour and drives registered rgb, de, hsync and vsync aligned to each other.

Parameters:
- H_SYNC, 128, hsync pulse width (clocks)
- H_BACK, 88, horizontal back porch
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch
- V_SYNC, 3, vsync pulse width (lines)
- V_BACK, 32, vertical back porch
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- PIX_LEAD, 1, cycles between coordinate request and colour return (legal 1..4)

Ports:
- clk  in  1  pixel clock
- rstn  in  1  asynchronous active-low reset
- color_data_in  in  24  colour for the coordinate requested PIX_LEAD cycles earlier, {R,G,B}
- pix_x  out  10  requested column 0..H_ACTIVE-1; 10'h3FF when no request
- pix_y  out  10  requested row 0..V_ACTIVE-1; 10'h3FF when no request
- hsync  out  1  active-low line sync
- vsync  out  1  active-low frame sync
- de  out  1  data enable, high on visible pixels
- rgb  out  24  displayed colour; 0 when de=0
- frame_start  out  1  one-cycle pulse at counter origin

Behaviour:
- Clock and reset: one clock (clk). Reset rstn is asynchronous, active-low.
- Constants:
  - H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT (1056); H_START = H_SYNC+H_BACK (216).
  - V_TOTAL = 525; V_START = 35.
- Counters:
  - h_cnt is 11 bits, 0..H_TOTAL-1, and increments every clock.
  - At h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - v_cnt is 10 bits and wraps to 0 after V_TOTAL-1, on the same edge that h_cnt wraps.
- Request window (registered, so it appears one cycle later):
  - Active when v_cnt is in [V_START, V_START+V_ACTIVE-1] and h_cnt is in [H_START-PIX_LEAD-1, H_START+H_ACTIVE-PIX_LEAD-2].
  - In the window: pix_x = h_cnt+PIX_LEAD+1-H_START and pix_y = v_cnt-V_START. Net effect: pix_x = X is visible while h_cnt = H_START+X-PIX_LEAD.
  - Outside the window, both pix_x and pix_y are 10'h3FF.
- Colour return: color_data_in is sampled at the edge closing the cycle in which h_cnt = H_START+X (that is, PIX_LEAD cycles after request X).
- Output stage (all outputs registered, one cycle after the counter state they decode):
  - hsync <= ~(h_cnt < H_SYNC)
  - vsync <= ~(v_cnt < V_SYNC)
  - de <= h_cnt and v_cnt both in the active range
  - rgb <= color_data_in when that active condition holds, else 24'h0
- Alignment: de, hsync, vsync and rgb always change on the same edge. 800 de-high cycles per active line, 480 active lines per frame.
- frame_start: registered pulse, high for exactly the cycle following h_cnt=0 and v_cnt=0. One pulse per H_TOTAL*V_TOTAL = 554400 clocks.
- Reset values:
  - h_cnt=0, v_cnt=0
  - hsync=1, vsync=1, de=0, rgb=0
  - pix_x=10'h3FF, pix_y=10'h3FF
  - frame_start=0
- Reset mid-frame: all outputs return to reset values immediately (asynchronously). After release, timing restarts from the origin; frame_start fires on the first cycle after counting resumes. No partial line is completed.
- Wrap boundary: at the last pixel of the last active line, the next request is 10'h3FF. No request is issued for pixels beyond H_ACTIVE-1 or rows beyond V_ACTIVE-1.

Optional Feature:
- Macro TEST_PATTERN_EN.
- Defined:
  - Adds input port pattern_sel (1 bit).
  - When pattern_sel=1, rgb in the active region is an 8-bar vertical pattern, bar index = X/(H_ACTIVE/8). Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - color_data_in is ignored in this mode; pix_x/pix_y, syncs and de are unchanged.
  - pattern_sel is sampled per pixel, so toggling it takes effect on the next output edge.
- Not defined: no pattern_sel port, no pattern logic; rgb always comes from color_data_in.

Test Plan:
- Reset release:
  - During reset, hsync=vsync=1, de=0, rgb=0, pix_x=pix_y=3FF.
  - frame_start pulses on the first clock after release.
  - hsync low for exactly 128 clocks starting on that edge.
- Line timing: measure a line -> hsync period 1056 clocks, hsync low 128, de high for 800 consecutive clocks starting 216 clocks after the hsync falling edge.
- Frame timing: run 2 frames -> vsync low for 3*1056 clocks, 480 lines with de activity, frame_start spacing 554400.
- Request/return alignment with PIX_LEAD=1 and 2:
  - Model returns color_data_in = {4'h0, pix_y, pix_x} delayed by PIX_LEAD.
  - Every de-high rgb equals {0, row, col}; first pixel of row 0 = 24'h000000, last pixel of row 479 = {4'h0, 10'd479, 10'd799}.
- Reset mid-line: assert rstn at v_cnt=100, h_cnt=500 -> outputs go to reset values with no clock edge; restart from origin after release.
- TEST_PATTERN_EN with pattern_sel=1 -> rgb at X=0 is FFFFFF, X=100 is FFFF00, X=799 is 000000, regardless of color_data_in.

Source files
------------

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: display timing controller for an 800x480 panel.
//
// Free-running horizontal/vertical counters drive registered sync, data-enable
// and colour outputs. Pixel coordinates are requested PIX_LEAD cycles before
// the pixel is displayed, so the colour source has time to look them up. The
// returned colour is then registered into rgb on the same edge as de/hsync/vsync.
//
// Optional build macro TEST_PATTERN_EN adds pattern_sel. When it is set, rgb
// shows eight vertical colour bars and color_data_in is ignored.
//
// Ports:
//   clk            pixel clock
//   rstn           asynchronous active-low reset
//   pattern_sel    (TEST_PATTERN_EN only) 1 = internal colour-bar pattern
//   color_data_in  {R,G,B} for the coordinate requested PIX_LEAD cycles earlier
//   pix_x, pix_y   requested column/row, 10'h3FF when no request is pending
//   hsync, vsync   active-low line/frame sync
//   de             high on visible pixels
//   rgb            displayed colour, zero when de is low
//   frame_start    one-cycle pulse following the counter origin
module lcd_timing_gen #(
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BACK   = 88,
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FRONT  = 40,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 32,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned PIX_LEAD = 1
) (
  input  logic        clk,
  input  logic        rstn,
`ifdef TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic [23:0] color_data_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int unsigned V_START = V_SYNC + V_BACK;

  localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
  localparam logic [10:0] HSyncEnd   = 11'(H_SYNC);
  localparam logic [10:0] HActFirst  = 11'(H_START);
  localparam logic [10:0] HActLast   = 11'(H_START + H_ACTIVE - 1);
  // Request window leads the active window by PIX_LEAD+1 cycles: one for the
  // request register, PIX_LEAD for the colour source.
  localparam logic [10:0] HReqFirst  = 11'(H_START - PIX_LEAD - 1);
  localparam logic [10:0] HReqLast   = 11'(H_START + H_ACTIVE - PIX_LEAD - 2);
  localparam logic [10:0] HReqOffset = 11'(H_START - PIX_LEAD - 1);
  localparam logic [9:0]  VLast      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VSyncEnd   = 10'(V_SYNC);
  localparam logic [9:0]  VActFirst  = 10'(V_START);
  localparam logic [9:0]  VActLast   = 10'(V_START + V_ACTIVE - 1);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [9:0]  v_cnt_q, v_cnt_d;
  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic [23:0] rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;

  logic h_wrap, v_wrap;
  logic h_act, v_act, h_req;

`ifdef TEST_PATTERN_EN
  localparam logic [10:0] BarWidth = 11'(H_ACTIVE / 8);
  logic [10:0] bar_x;
  logic [10:0] bar_div;
  logic [2:0]  bar_idx;
  logic [23:0] bar_color;

  always_comb begin
    bar_x   = h_cnt_q - HActFirst;
    bar_div = bar_x / BarWidth;
    // Clamp covers H_ACTIVE values that are not a multiple of eight.
    bar_idx = (bar_div > 11'd7) ? 3'd7 : bar_div[2:0];
    unique case (bar_idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFFFF00;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h00FF00;
      3'd4:    bar_color = 24'hFF00FF;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h0000FF;
      default: bar_color = 24'h000000;
    endcase
  end
`endif

  always_comb begin
    h_wrap = (h_cnt_q == HLast);
    v_wrap = (v_cnt_q == VLast);

    h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
    end

    h_act = (h_cnt_q >= HActFirst) && (h_cnt_q <= HActLast);
    v_act = (v_cnt_q >= VActFirst) && (v_cnt_q <= VActLast);
    h_req = (h_cnt_q >= HReqFirst) && (h_cnt_q <= HReqLast);

    pix_x_d = 10'h3FF;
    pix_y_d = 10'h3FF;
    if (v_act && h_req) begin
      pix_x_d = 10'(h_cnt_q - HReqOffset);
      pix_y_d = v_cnt_q - VActFirst;
    end

    hsync_d       = ~(h_cnt_q < HSyncEnd);
    vsync_d       = ~(v_cnt_q < VSyncEnd);
    de_d          = h_act && v_act;
    frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);

    rgb_d = 24'h0;
    if (de_d) begin
`ifdef TEST_PATTERN_EN
      rgb_d = pattern_sel ? bar_color : color_data_in;
`else
      rgb_d = color_data_in;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 10'd0;
      pix_x_q       <= 10'h3FF;
      pix_y_q       <= 10'h3FF;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      rgb_q         <= 24'h0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen. Instance A uses the 800x480 timing with PIX_LEAD=1;
// instance B uses a reduced timing (25 x 13 clocks per frame) with PIX_LEAD=2
// so whole frames and a mid-line reset fit in a short run. Both have a colour
// source returning {4'h0, pix_y, pix_x} PIX_LEAD cycles after the request.
module tb_lcd_timing_gen;

  // Instance A: panel timing.
  localparam int A_HS = 128, A_HB = 88, A_HA = 800, A_HF = 40;
  localparam int A_VS = 3, A_VB = 32, A_VA = 480, A_VF = 10, A_L = 1;
  localparam int A_HT = A_HS + A_HB + A_HA + A_HF;
  // Instance B: reduced timing.
  localparam int B_HS = 4, B_HB = 3, B_HA = 16, B_HF = 2;
  localparam int B_VS = 2, B_VB = 3, B_VA = 6, B_VF = 2, B_L = 2;
  localparam int B_HT = B_HS + B_HB + B_HA + B_HF;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [23:0] rgb;
    logic [9:0] px;
    logic [9:0] py;
  } obs_t;

  typedef struct {
    int   k;
    obs_t o;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn_a, rstn_b;
  logic sel_a = 1'b0;
  logic sel_b = 1'b0;
  logic [23:0] col_a = 24'h0;
  logic [23:0] pipe_b0 = 24'h0;
  logic [23:0] pipe_b1 = 24'h0;
  logic [23:0] rgb_a, rgb_b;
  logic [9:0]  px_a, py_a, px_b, py_b;
  logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;

  int n_cmp  = 0;
  int n_fail = 0;

  lcd_timing_gen #(
    .H_SYNC(A_HS), .H_BACK(A_HB), .H_ACTIVE(A_HA), .H_FRONT(A_HF),
    .V_SYNC(A_VS), .V_BACK(A_VB), .V_ACTIVE(A_VA), .V_FRONT(A_VF), .PIX_LEAD(A_L)
  ) u_dut_a (
    .clk          (clk),
    .rstn         (rstn_a),
`ifdef TEST_PATTERN_EN
    .pattern_sel  (sel_a),
`endif
    .color_data_in(col_a),
    .pix_x        (px_a),
    .pix_y        (py_a),
    .hsync        (hs_a),
    .vsync        (vs_a),
    .de           (de_a),
    .rgb          (rgb_a),
    .frame_start  (fs_a)
  );

  lcd_timing_gen #(
    .H_SYNC(B_HS), .H_BACK(B_HB), .H_ACTIVE(B_HA), .H_FRONT(B_HF),
    .V_SYNC(B_VS), .V_BACK(B_VB), .V_ACTIVE(B_VA), .V_FRONT(B_VF), .PIX_LEAD(B_L)
  ) u_dut_b (
    .clk          (clk),
    .rstn         (rstn_b),
`ifdef TEST_PATTERN_EN
    .pattern_sel  (sel_b),
`endif
    .color_data_in(pipe_b1),
    .pix_x        (px_b),
    .pix_y        (py_b),
    .hsync        (hs_b),
    .vsync        (vs_b),
    .de           (de_b),
    .rgb          (rgb_b),
    .frame_start  (fs_b)
  );

  obs_t obs_a, obs_b;
  assign obs_a = {hs_a, vs_a, de_a, fs_a, rgb_a, px_a, py_a};
  assign obs_b = {hs_b, vs_b, de_b, fs_b, rgb_b, px_b, py_b};

  // Colour source: return the requested coordinate PIX_LEAD cycles later.
  always @(posedge clk) begin
    col_a   <= {4'h0, py_a, px_a};
    pipe_b0 <= {4'h0, py_b, px_b};
    pipe_b1 <= pipe_b0;
  end

  // Cycle index since reset release: 0 after the first edge out of reset.
  int cnt_a = -1;
  int cnt_b = -1;
  always @(posedge clk or negedge rstn_a) begin
    if (!rstn_a) cnt_a <= -1;
    else         cnt_a <= cnt_a + 1;
  end
  always @(posedge clk or negedge rstn_b) begin
    if (!rstn_b) cnt_b <= -1;
    else         cnt_b <= cnt_b + 1;
  end

  function automatic obs_t mk(logic hs, logic vs, logic de, logic fs, logic [23:0] rgb,
                              logic [9:0] px, logic [9:0] py);
    return {hs, vs, de, fs, rgb, px, py};
  endfunction

  function automatic logic [23:0] bar_color(int i);
    case (i)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected outputs after edge k, straight from the timing equations.
  function automatic obs_t model(int k, int hs_w, int hb, int ha, int hf, int vs_w, int vb,
                                 int va, int vf, int lead, logic sel);
    obs_t o;
    int ht  = hs_w + hb + ha + hf;
    int vt  = vs_w + vb + va + vf;
    int hst = hs_w + hb;
    int vst = vs_w + vb;
    int h   = k % ht;
    int v   = (k / ht) % vt;
    bit v_ok = (v >= vst) && (v < vst + va);
    bit h_ok = (h >= hst) && (h < hst + ha);
    bit rq   = v_ok && (h >= hst - lead - 1) && (h <= hst + ha - lead - 2);
    o.hs  = !(h < hs_w);
    o.vs  = !(v < vs_w);
    o.de  = v_ok && h_ok;
    o.fs  = (h == 0) && (v == 0);
    o.px  = rq ? 10'(h + lead + 1 - hst) : 10'h3FF;
    o.py  = rq ? 10'(v - vst) : 10'h3FF;
    o.rgb = 24'h0;
    if (o.de) o.rgb = sel ? bar_color((h - hst) / (ha / 8)) : {4'h0, 10'(v - vst), 10'(h - hst)};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Every cycle is compared with the model; one comparison per completed line.
  int   bad_a = 0, bad_b = 0;
  obs_t fb_act_a, fb_exp_a, fb_act_b, fb_exp_b;
  always @(negedge clk) begin : line_chk_a
    obs_t e;
    if (cnt_a < 0) begin
      bad_a = 0;
    end else begin
      e = model(cnt_a, A_HS, A_HB, A_HA, A_HF, A_VS, A_VB, A_VA, A_VF, A_L, sel_a);
      if (obs_a !== e) begin
        if (bad_a == 0) begin
          fb_act_a = obs_a;
          fb_exp_a = e;
        end
        bad_a++;
      end
      if (cnt_a % A_HT == A_HT - 1) begin
        chk($sformatf("A line %0d bad cycles", cnt_a / A_HT), 48'(bad_a), 48'd0);
        if (bad_a != 0) $display("  first differing cycle: got %h want %h", fb_act_a, fb_exp_a);
        bad_a = 0;
      end
    end
  end

  always @(negedge clk) begin : line_chk_b
    obs_t e;
    if (cnt_b < 0) begin
      bad_b = 0;
    end else begin
      e = model(cnt_b, B_HS, B_HB, B_HA, B_HF, B_VS, B_VB, B_VA, B_VF, B_L, sel_b);
      if (obs_b !== e) begin
        if (bad_b == 0) begin
          fb_act_b = obs_b;
          fb_exp_b = e;
        end
        bad_b++;
      end
      if (cnt_b % B_HT == B_HT - 1) begin
        chk($sformatf("B line %0d bad cycles", cnt_b / B_HT), 48'(bad_b), 48'd0);
        if (bad_b != 0) $display("  first differing cycle: got %h want %h", fb_act_b, fb_exp_b);
        bad_b = 0;
      end
    end
  end

  task automatic wait_a(input int k);
    while (cnt_a < k) @(negedge clk);
  endtask

  task automatic wait_b(input int k);
    while (cnt_b < k) @(negedge clk);
  endtask

  task automatic flow_a();
    vec_t vecs[19];
    logic [23:0] exp0, exp100, exp799;
    vecs[0]  = '{0,     mk(0, 0, 0, 1, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[1]  = '{1,     mk(0, 0, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[2]  = '{127,   mk(0, 0, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[3]  = '{128,   mk(1, 0, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[4]  = '{1056,  mk(0, 0, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[5]  = '{3167,  mk(1, 0, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[6]  = '{3168,  mk(0, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[7]  = '{36959, mk(1, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[8]  = '{37173, mk(1, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[9]  = '{37174, mk(1, 1, 0, 0, 24'h0, 10'h000, 10'h000)};
    vecs[10] = '{37175, mk(1, 1, 0, 0, 24'h0, 10'h001, 10'h000)};
    vecs[11] = '{37176, mk(1, 1, 1, 0, 24'h000000, 10'h002, 10'h000)};
    vecs[12] = '{37675, mk(1, 1, 1, 0, 24'h0001F3, 10'h1F5, 10'h000)};
    vecs[13] = '{37973, mk(1, 1, 1, 0, 24'h00031D, 10'h31F, 10'h000)};
    vecs[14] = '{37974, mk(1, 1, 1, 0, 24'h00031E, 10'h3FF, 10'h3FF)};
    vecs[15] = '{37975, mk(1, 1, 1, 0, 24'h00031F, 10'h3FF, 10'h3FF)};
    vecs[16] = '{37976, mk(1, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[17] = '{38016, mk(0, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF)};
    vecs[18] = '{38230, mk(1, 1, 0, 0, 24'h0, 10'h000, 10'h001)};
    for (int i = 0; i < 19; i++) begin
      wait_a(vecs[i].k);
      chk($sformatf("A vec k=%0d", vecs[i].k), obs_a, vecs[i].o);
    end
    // Row 1: colour bars when the pattern feature is built in, otherwise the
    // returned coordinate.
`ifdef TEST_PATTERN_EN
    sel_a  = 1'b1;
    exp0   = 24'hFFFFFF;
    exp100 = 24'hFFFF00;
    exp799 = 24'h000000;
`else
    exp0   = 24'h000400;
    exp100 = 24'h000464;
    exp799 = 24'h00071F;
`endif
    wait_a(38232);
    chk("A row1 X=0 rgb", 48'(rgb_a), 48'(exp0));
    wait_a(38332);
    chk("A row1 X=100 rgb", 48'(rgb_a), 48'(exp100));
    wait_a(39031);
    chk("A row1 X=799 rgb", 48'(rgb_a), 48'(exp799));
    chk("A row1 X=799 de", 48'(de_a), 48'd1);
    wait_a(39040);
    sel_a = 1'b0;
    wait_a(39075);
  endtask

  task automatic flow_b();
    int fs_cnt = 0, last_fs = -1, spacing = 0, de_cnt = 0, vs_low = 0;
    int hs_low = 0, de_rise = 0, first_de = -1;
    logic prev_de = 1'b0;
    for (int k = 0; k < 650; k++) begin
      wait_b(k);
      if (fs_b === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) spacing = k - last_fs;
        last_fs = k;
      end
      if (de_b === 1'b1) de_cnt++;
      if (vs_b === 1'b0) vs_low++;
      if (k < B_HT && hs_b === 1'b0) hs_low++;
      if (de_b === 1'b1 && prev_de === 1'b0) de_rise++;
      if (de_b === 1'b1 && first_de < 0) first_de = k;
      prev_de = de_b;
      if (k == 269) chk("B last request", {px_b, py_b}, {10'd15, 10'd5});
      if (k == 270) chk("B request after last", {px_b, py_b}, {10'h3FF, 10'h3FF});
      if (k == 272) chk("B last pixel", {de_b, rgb_b}, {1'b1, 24'h00140F});
      if (k == 273) chk("B after last pixel", {de_b, rgb_b}, {1'b0, 24'h0});
    end
    chk("B frame_start count", 48'(fs_cnt), 48'd2);
    chk("B frame_start spacing", 48'(spacing), 48'd325);
    chk("B de cycles 2 frames", 48'(de_cnt), 48'd192);
    chk("B vsync low cycles", 48'(vs_low), 48'd100);
    chk("B hsync low per line", 48'(hs_low), 48'd4);
    chk("B active line count", 48'(de_rise), 48'd12);
    chk("B first de cycle", 48'(first_de), 48'd132);
    // Reset in the middle of an active line, between clock edges.
    wait_b(862);
    chk("B pre-reset de", 48'(de_b), 48'd1);
    #2;
    rstn_b = 1'b0;
    #1;
    chk("B async reset", obs_b, mk(1, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF));
    @(negedge clk);
    @(negedge clk);
    chk("B reset held", obs_b, mk(1, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF));
    rstn_b = 1'b1;
    wait_b(0);
    chk("B restart origin", obs_b, mk(0, 0, 0, 1, 24'h0, 10'h3FF, 10'h3FF));
    wait_b(400);
  endtask

  initial begin
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("A reset outputs", obs_a, mk(1, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF));
    chk("B reset outputs", obs_b, mk(1, 1, 0, 0, 24'h0, 10'h3FF, 10'h3FF));
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    fork
      flow_a();
      flow_b();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
